systolic_result_drain: RTL and testbench

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

---
 rtl/systolic_pkg.sv | 8 +
 rtl/accum_saturate.sv | 30 +++
 rtl/systolic_result_drain.sv | 102 ++++++++++
 tb/tb_systolic_result_drain.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and drain FSM state for the systolic array result path.
package systolic_pkg;
  localparam int N_DEF           = 4;
  localparam int ACCUM_WIDTH_DEF = 40;
  localparam int OUT_WIDTH_DEF   = 32;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} drain_state_t;
endpackage

// File: rtl/accum_saturate.sv
// Signed clamp of one accumulator down to the streamed result width.
module accum_saturate
  import systolic_pkg::*;
#(
  parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF
) (
  input  logic signed [ACCUM_WIDTH-1:0] acc,
  output logic        [OUT_WIDTH-1:0]   res,
  output logic                          sat
);
  localparam logic signed [ACCUM_WIDTH-1:0] MAX_V =
    {{(ACCUM_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH-1:0] MIN_V =
    {{(ACCUM_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    res = acc[OUT_WIDTH-1:0];
    sat = 1'b0;
    if (acc > MAX_V) begin
      res = OUT_MAX;
      sat = 1'b1;
    end else if (acc < MIN_V) begin
      res = OUT_MIN;
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the NxN accumulator array on capture and streams it row-major
// as saturated beats over a valid/ready interface.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N*N*ACCUM_WIDTH-1:0]     result_c_flat,
  input  logic                           capture,
  output logic                           capture_ready,
  output logic                           pe_clear,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic [$clog2(N)-1:0]           out_row,
  output logic [$clog2(N)-1:0]           out_col,
  output logic                           out_last,
  output logic                           out_sat,
  output logic                           overrun
);
  localparam int NN    = N * N;
  localparam int RC_W  = $clog2(N);
  localparam int IDX_W = $clog2(NN);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(N - 1);

  drain_state_t                  state, state_nxt;
  logic [NN-1:0][OUT_WIDTH-1:0]  lane_res, snap_data;
  logic [NN-1:0]                 lane_sat, snap_sat;
  logic [RC_W-1:0]               row, col;
  logic [IDX_W-1:0]              idx;
  logic                          take, beat, at_last;

  // Saturate every lane at capture so the snapshot holds only OUT_WIDTH+1 bits per element.
  for (genvar e = 0; e < NN; e++) begin : g_lane
    accum_saturate #(
      .ACCUM_WIDTH(ACCUM_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH)
    ) u_sat (
      .acc(result_c_flat[e*ACCUM_WIDTH +: ACCUM_WIDTH]),
      .res(lane_res[e]),
      .sat(lane_sat[e])
    );
  end

  assign capture_ready = (state == IDLE);
  assign out_valid     = (state == DRAIN);
  assign take          = capture && capture_ready;
  assign beat          = out_valid && out_ready;
  assign at_last       = (row == RC_LAST) && (col == RC_LAST);
  assign idx           = IDX_W'(row) * IDX_W'(N) + IDX_W'(col);

  assign out_row  = row;
  assign out_col  = col;
  assign out_last = out_valid && at_last;
  assign out_data = out_valid ? snap_data[idx] : '0;
  assign out_sat  = out_valid && snap_sat[idx];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (take)              state_nxt = DRAIN;
      DRAIN: if (beat && at_last)   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_data <= '0;
      snap_sat  <= '0;
      row       <= '0;
      col       <= '0;
      pe_clear  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pe_clear <= take;
      if (capture && !capture_ready) overrun <= 1'b1;
      if (take) begin
        snap_data <= lane_res;
        snap_sat  <= lane_sat;
        row       <= '0;
        col       <= '0;
      end else if (beat) begin
        // Coordinates wrap to (0,0) after the last beat.
        if (col == RC_LAST) begin
          col <= '0;
          row <= at_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: table-driven saturation plus drain corner cases.
module tb_systolic_result_drain;
  localparam int N  = 4;
  localparam int AW = 40;
  localparam int OW = 32;
  localparam int NN = N * N;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              capture = 1'b0;
  logic              out_ready = 1'b0;
  logic [NN*AW-1:0]  result_c_flat = '0;
  logic              capture_ready, pe_clear, out_valid, out_last, out_sat, overrun;
  logic [OW-1:0]     out_data;
  logic [1:0]        out_row, out_col;

  always #5 clk = ~clk;

  systolic_result_drain #(.N(N), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .result_c_flat(result_c_flat),
    .capture(capture), .capture_ready(capture_ready), .pe_clear(pe_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .out_sat(out_sat), .overrun(overrun)
  );

  typedef struct {
    longint        acc;
    logic [OW-1:0] dat;
    logic          sat;
  } sat_vec_t;

  sat_vec_t      tv[NN];
  longint        mat[NN];
  logic [OW+5:0] exp_q[$];
  logic [OW+5:0] hold_beat;
  logic          hold_pend = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [OW+5:0] cur_beat();
    return {out_data, out_row, out_col, out_last, out_sat};
  endfunction

  function automatic logic [OW+5:0] mk_beat(input logic [OW-1:0] d, input int k, input logic s);
    return {d, 2'(k / N), 2'(k % N), (k == NN - 1), s};
  endfunction

  // Independent reference clamp to 32-bit signed.
  task automatic sat_model(input longint v, output logic [OW-1:0] d, output logic s);
    if (v > 64'sd2147483647) begin
      d = 32'h7fff_ffff; s = 1'b1;
    end else if (v < -64'sd2147483648) begin
      d = 32'h8000_0000; s = 1'b1;
    end else begin
      d = v[OW-1:0]; s = 1'b0;
    end
  endtask

  task automatic load_mat();
    for (int e = 0; e < NN; e++) result_c_flat[e*AW +: AW] = AW'(mat[e]);
  endtask

  task automatic push_model();
    logic [OW-1:0] d;
    logic          s;
    for (int k = 0; k < NN; k++) begin
      sat_model(mat[k], d, s);
      exp_q.push_back(mk_beat(d, k, s));
    end
  endtask

  task automatic scramble();
    for (int e = 0; e < NN; e++) result_c_flat[e*AW +: AW] = AW'({$urandom, $urandom});
  endtask

  // Called at a negedge with this cycle's inputs already applied.
  task automatic monitor();
    if (out_valid) begin
      if (hold_pend) chk("hold_stable", 64'(cur_beat()), 64'(hold_beat));
      if (out_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 64'(cur_beat()), 64'hdead);
        else chk("beat", 64'(cur_beat()), 64'(exp_q.pop_front()));
        hold_pend = 1'b0;
      end else begin
        hold_beat = cur_beat();
        hold_pend = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    monitor();
    @(negedge clk);
  endtask

  task automatic do_capture();
    capture = 1'b1;
    cyc();
    capture = 1'b0;
  endtask

  task automatic drain_all(input bit bp, input bit scr);
    logic [3:0] pat = 4'b1001;
    int g = 0;
    while ((out_valid || exp_q.size() != 0) && g < 300) begin
      out_ready = bp ? pat[g % 4] : 1'b1;
      if (scr) scramble();
      cyc();
      g++;
    end
    if (g >= 300) chk("drain_timeout", 64'(g), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;
    hold_pend = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{64'sd34359738368,   32'h7fff_ffff, 1'b1};
    tv[1]  = '{-64'sd34359738368,  32'h8000_0000, 1'b1};
    tv[2]  = '{-64'sd5,            32'hffff_fffb, 1'b0};
    tv[3]  = '{64'sd2147483647,    32'h7fff_ffff, 1'b0};
    tv[4]  = '{64'sd2147483648,    32'h7fff_ffff, 1'b1};
    tv[5]  = '{-64'sd2147483648,   32'h8000_0000, 1'b0};
    tv[6]  = '{-64'sd2147483649,   32'h8000_0000, 1'b1};
    tv[7]  = '{64'sd0,             32'h0000_0000, 1'b0};
    tv[8]  = '{64'sd549755813887,  32'h7fff_ffff, 1'b1};
    tv[9]  = '{-64'sd549755813888, 32'h8000_0000, 1'b1};
    tv[10] = '{64'sd123456789,     32'h075b_cd15, 1'b0};
    tv[11] = '{-64'sd1,            32'hffff_ffff, 1'b0};
    tv[12] = '{64'sd4294967296,    32'h7fff_ffff, 1'b1};
    tv[13] = '{-64'sd123456789,    32'hf8a4_32eb, 1'b0};
    tv[14] = '{64'sd1,             32'h0000_0001, 1'b0};
    tv[15] = '{64'sd2147483646,    32'h7fff_fffe, 1'b0};

    @(negedge clk);
    // Reset state
    cyc(); cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_capture_ready", 64'(capture_ready), 64'd1);
    chk("rst_pe_clear", 64'(pe_clear), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_beat_fields", 64'(cur_beat()), 64'd0);
    reset = 1'b1;
    cyc();

    // Basic drain, ready held high
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i*N+j] = 10 * i + j;
    load_mat();
    push_model();
    out_ready = 1'b1;
    do_capture();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("pe_clear_pulse", 64'(pe_clear), 64'd1);
    for (int t = 1; t <= NN; t++) begin
      if (t == 2)  chk("pe_clear_drop", 64'(pe_clear), 64'd0);
      if (t == NN) chk("busy_ready_low", 64'(capture_ready), 64'd0);
      cyc();
    end
    chk("ready_back", 64'(capture_ready), 64'd1);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("basic_all_beats", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;
    cyc();

    // Backpressure 1,0,0,1
    for (int e = 0; e < NN; e++) mat[e] = longint'($urandom_range(0, 2000000)) - 64'sd1000000;
    mat[3] = 64'sd3000000000;
    load_mat();
    push_model();
    do_capture();
    drain_all(1'b1, 1'b0);
    cyc();

    // Saturation table
    for (int e = 0; e < NN; e++) begin
      mat[e] = tv[e].acc;
      exp_q.push_back(mk_beat(tv[e].dat, e, tv[e].sat));
    end
    load_mat();
    do_capture();
    drain_all(1'b0, 1'b0);
    cyc();

    // Input changes after capture must not leak into the stream
    for (int e = 0; e < NN; e++) mat[e] = longint'($urandom_range(0, 5000)) * 64'sd1000000 - 64'sd2500000000;
    load_mat();
    push_model();
    do_capture();
    drain_all(1'b1, 1'b1);
    cyc();

    // Overrun: capture while draining at beat 5
    for (int e = 0; e < NN; e++) mat[e] = 64'sd7 * e - 64'sd50;
    load_mat();
    push_model();
    chk("overrun_clear", 64'(overrun), 64'd0);
    out_ready = 1'b1;
    do_capture();
    for (int t = 1; t <= 5; t++) cyc();
    chk("busy_no_ready", 64'(capture_ready), 64'd0);
    scramble();
    capture = 1'b1;
    cyc();
    capture = 1'b0;
    chk("overrun_set", 64'(overrun), 64'd1);
    drain_all(1'b0, 1'b0);
    cyc(); cyc();
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // Reset mid-drain at beat 7, then a fresh capture streams from (0,0)
    for (int e = 0; e < NN; e++) mat[e] = 64'sd1000 + e;
    load_mat();
    push_model();
    out_ready = 1'b1;
    do_capture();
    for (int t = 1; t <= 7; t++) cyc();
    reset = 1'b0;
    out_ready = 1'b0;
    cyc();
    reset = 1'b1;
    hold_pend = 1'b0;
    exp_q.delete();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(capture_ready), 64'd1);
    chk("midrst_overrun", 64'(overrun), 64'd0);
    cyc();
    for (int e = 0; e < NN; e++) mat[e] = -64'sd300 * e;
    load_mat();
    push_model();
    do_capture();
    chk("restart_row", 64'(out_row), 64'd0);
    chk("restart_col", 64'(out_col), 64'd0);
    drain_all(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
